// File: rtl/pin_conditioner_pkg.sv
// rtl/pin_conditioner_pkg.sv - shared defaults, register addresses and debounce state type
package pin_conditioner_pkg;

  localparam int DATA_WIDTH_DEF      = 8;
  localparam int DEBOUNCE_CYCLES_DEF = 4;

  localparam logic [7:0] PCMSKA_ADDR = 8'h6B;
  localparam logic [7:0] PCMSKB_ADDR = 8'h6C;
  localparam logic [7:0] PCIFR_ADDR  = 8'h3B;

  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_COUNTING = 1'b1
  } db_state_e;

endpackage

// File: rtl/pin_debounce_bit.sv
// rtl/pin_debounce_bit.sv - one-bit synchronizer plus debounce counter and state machine
module pin_debounce_bit
  import pin_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic pin_raw,
  input  logic ddr,
  output logic clean,
  output logic accept
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] count;
  db_state_e     state;

  // count is 0 in STABLE, so a single differing sample is accepted at once when DEBOUNCE_CYCLES is 1
  assign accept = !ddr && (sync2 != clean) && (count == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      clean <= 1'b0;
      count <= '0;
      state <= ST_STABLE;
    end else begin
      sync1 <= pin_raw;
      sync2 <= sync1;
      if (ddr) begin
        // clean takes the value sync2 is being loaded with, so it tracks sync2 exactly
        clean <= sync1;
        count <= '0;
        state <= ST_STABLE;
      end else if (sync2 == clean) begin
        count <= '0;
        state <= ST_STABLE;
      end else if (count == LAST) begin
        clean <= sync2;
        count <= '0;
        state <= ST_STABLE;
      end else begin
        count <= count + CW'(1);
        state <= ST_COUNTING;
      end
    end
  end

endmodule

// File: rtl/pin_conditioner.sv
// rtl/pin_conditioner.sv - per-pin debounce array with sticky pin-change flags and interrupt
module pin_conditioner
  import pin_conditioner_pkg::*;
#(
  parameter int DATA_WIDTH      = DATA_WIDTH_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] pin_raw,
  input  logic [DATA_WIDTH-1:0] ddr,
  input  logic [DATA_WIDTH-1:0] pcmsk,
  input  logic                  irq_ack,
  output logic [DATA_WIDTH-1:0] pin_clean,
  output logic [DATA_WIDTH-1:0] pc_bits,
  output logic                  irq
);

  logic [DATA_WIDTH-1:0] accept;
  logic [DATA_WIDTH-1:0] change_event;

  for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_bit
    pin_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk    (clk),
      .reset  (reset),
      .pin_raw(pin_raw[i]),
      .ddr    (ddr[i]),
      .clean  (pin_clean[i]),
      .accept (accept[i])
    );
  end

  assign change_event = accept & pcmsk;

  // new events are OR-ed in after the acknowledge clear, so a simultaneous event survives
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_bits <= '0;
      irq     <= 1'b0;
    end else begin
      pc_bits <= (irq_ack ? '0 : pc_bits) | change_event;
      irq     <= (irq_ack ? 1'b0 : irq) | (|change_event);
    end
  end

endmodule

// File: tb/tb_pin_conditioner.sv
// tb/tb_pin_conditioner.sv - vector table, directed corner sequences and randomized model check
module tb_pin_conditioner;

  localparam int W = 8;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] pin_raw, ddr, pcmsk;
  logic         irq_ack;
  logic [W-1:0] pin_clean, pc_bits;
  logic         irq;

  pin_conditioner #(.DATA_WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .reset(reset), .pin_raw(pin_raw), .ddr(ddr), .pcmsk(pcmsk),
    .irq_ack(irq_ack), .pin_clean(pin_clean), .pc_bits(pc_bits), .irq(irq)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  // reference: a bit adopts a new level once the last D synchronized samples all show it
  logic [W-1:0] m_s1, m_s2, m_clean, m_pc;
  logic         m_irq;
  int           hist[W][D];

  typedef struct {
    logic [W-1:0] raw, ddr, pcmsk;
    logic         ack;
    logic [W-1:0] clean, pc;
    logic         irq;
  } vec_t;
  vec_t tab[$];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_clear();
    m_s1 = '0; m_s2 = '0; m_clean = '0; m_pc = '0; m_irq = 1'b0;
    for (int b = 0; b < W; b++)
      for (int k = 0; k < D; k++) hist[b][k] = 2;
  endtask

  task automatic model_edge();
    logic [W-1:0] nclean, ev;
    bit all_same;
    nclean = m_clean;
    ev = '0;
    for (int b = 0; b < W; b++) begin
      if (ddr[b]) begin
        nclean[b] = m_s1[b];
        for (int k = 0; k < D; k++) hist[b][k] = 2;
      end else begin
        for (int k = D - 1; k > 0; k--) hist[b][k] = hist[b][k-1];
        hist[b][0] = int'(m_s2[b]);
        all_same = 1'b1;
        for (int k = 0; k < D; k++) if (hist[b][k] != int'(m_s2[b])) all_same = 1'b0;
        if (all_same && m_s2[b] != m_clean[b]) begin
          nclean[b] = m_s2[b];
          ev[b] = pcmsk[b];
        end
      end
    end
    m_pc    = (irq_ack ? '0 : m_pc) | ev;
    m_irq   = (irq_ack ? 1'b0 : m_irq) | (|ev);
    m_clean = nclean;
    m_s2    = m_s1;
    m_s1    = pin_raw;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    chk("model_clean", pin_clean, m_clean);
    chk("model_pc_bits", pc_bits, m_pc);
    chk("model_irq", W'(irq), W'(m_irq));
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    model_clear();
    chk("reset_clean", pin_clean, '0);
    chk("reset_pc_bits", pc_bits, '0);
    chk("reset_irq", W'(irq), '0);
    #1 reset = 1'b1;
  endtask

  task automatic run_table();
    for (int i = 0; i < tab.size(); i++) begin
      pin_raw = tab[i].raw; ddr = tab[i].ddr; pcmsk = tab[i].pcmsk; irq_ack = tab[i].ack;
      tick();
      chk($sformatf("tab%0d_clean", i), pin_clean, tab[i].clean);
      chk($sformatf("tab%0d_pc_bits", i), pc_bits, tab[i].pc);
      chk($sformatf("tab%0d_irq", i), W'(irq), W'(tab[i].irq));
    end
    tab.delete();
  endtask

  initial begin
    pin_raw = 8'hFF; ddr = 8'h00; pcmsk = 8'h01; irq_ack = 1'b0; reset = 1'b1;

    // pin held high through reset: debounced like any change, flags the masked bit
    do_reset();
    for (int i = 1; i <= 5; i++) tab.push_back('{8'hFF, 8'h00, 8'h01, 1'b0, 8'h00, 8'h00, 1'b0});
    tab.push_back('{8'hFF, 8'h00, 8'h01, 1'b0, 8'hFF, 8'h01, 1'b1});
    tab.push_back('{8'hFF, 8'h00, 8'h01, 1'b0, 8'hFF, 8'h01, 1'b1});
    run_table();

    // output bits bypass debounce, input bits keep full latency, masked out so no irq
    pin_raw = 8'hFF; ddr = 8'hF0; pcmsk = 8'h00;
    do_reset();
    tab.push_back('{8'hFF, 8'hF0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0});
    for (int i = 2; i <= 5; i++) tab.push_back('{8'hFF, 8'hF0, 8'h00, 1'b0, 8'hF0, 8'h00, 1'b0});
    tab.push_back('{8'hFF, 8'hF0, 8'h00, 1'b0, 8'hFF, 8'h00, 1'b0});
    tab.push_back('{8'hFF, 8'hF0, 8'h00, 1'b0, 8'hFF, 8'h00, 1'b0});
    run_table();

    // three-sample glitch on bit3 is rejected
    pin_raw = 8'h00; ddr = 8'h00; pcmsk = 8'hFF;
    do_reset();
    repeat (3) tick();
    pin_raw = 8'h08;
    repeat (3) tick();
    pin_raw = 8'h00;
    repeat (6) tick();
    chk("glitch_clean", pin_clean, 8'h00);
    chk("glitch_irq", W'(irq), '0);

    // acknowledge clears everything on the next edge
    pin_raw = 8'h05;
    repeat (6) tick();
    chk("pre_ack_pc_bits", pc_bits, 8'h05);
    chk("pre_ack_irq", W'(irq), 8'h01);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    chk("ack_pc_bits", pc_bits, 8'h00);
    chk("ack_irq", W'(irq), '0);
    tick();
    chk("post_ack_pc_bits", pc_bits, 8'h00);

    // bit0 accepted on the same edge as irq_ack: the new event wins
    pin_raw = 8'h04;
    repeat (5) tick();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    chk("ack_race_clean", pin_clean, 8'h04);
    chk("ack_race_pc_bits", pc_bits, 8'h01);
    chk("ack_race_irq", W'(irq), 8'h01);

    // half-cycle async reset while bit2 is mid-count
    pin_raw = 8'h00;
    repeat (4) tick();
    #1 reset = 1'b0;
    #1;
    model_clear();
    chk("async_rst_clean", pin_clean, '0);
    chk("async_rst_pc_bits", pc_bits, '0);
    chk("async_rst_irq", W'(irq), '0);
    #4 reset = 1'b1;
    pin_raw = 8'h04;
    repeat (5) tick();
    chk("post_rst_hold_clean", pin_clean, 8'h00);
    tick();
    chk("post_rst_clean", pin_clean, 8'h04);
    chk("post_rst_pc_bits", pc_bits, 8'h04);
    chk("post_rst_irq", W'(irq), 8'h01);

    // randomized traffic against the reference model
    for (int i = 0; i < 600; i++) begin
      for (int b = 0; b < W; b++)
        if ($urandom_range(0, 7) == 0) pin_raw[b] = ~pin_raw[b];
      if ($urandom_range(0, 31) == 0) ddr = W'($urandom_range(0, 255));
      if ($urandom_range(0, 15) == 0) pcmsk = W'($urandom_range(0, 255));
      irq_ack = ($urandom_range(0, 7) == 0);
      if (i == 300) do_reset();
      tick();
    end
    irq_ack = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
